// File: rtl/hififo_pkg.sv
// rtl/hififo_pkg.sv - shared TLP constants, read-request FSM states and DW0 builder
package hififo_pkg;

   localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
   localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
   localparam logic [4:0] TYPE_MEM       = 5'b00000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR0 = 2'd1,
      HDR1 = 2'd2
   } rr_state_t;

   // DW0 of a memory read request: fmt/type, zeroed TC/attr/TD/EP fields, length in DW
   function automatic logic [31:0] build_dw0(input logic [2:0] fmt, input logic [9:0] len_dw);
      return {fmt, TYPE_MEM, 8'h00, 6'h00, len_dw};
   endfunction

endpackage

// File: rtl/hififo_rr_tlp.sv
// rtl/hififo_rr_tlp.sv - serialises one FIFO read request into a Memory Read TLP; optional HIFIFO_RR_4DW_EN
module hififo_rr_tlp
   import hififo_pkg::*;
#(
   parameter int                  TAG_BITS = 3,
   parameter logic [7-TAG_BITS:0] TAG_BASE = '0,
   parameter int                  LEN_DW   = 128
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [15:0]         requester_id,
   input  logic                rr_valid,
   input  logic [63:0]         rr_addr,
   output logic                rr_ready,
   output logic [63:0]         tx_data,
   output logic [7:0]          tx_keep,
   output logic                tx_valid,
   output logic                tx_last,
   input  logic                tx_ready,
   output logic [TAG_BITS-1:0] tag_count
);

   localparam logic [9:0] LEN_FIELD = 10'(LEN_DW);

   rr_state_t           state;
   rr_state_t           state_next;
   logic                accept;
   logic [TAG_BITS-1:0] tag_cnt;
   logic [31:2]         addr_lo_q;
   logic [15:0]         req_id_q;
   logic [7:0]          tag_q;
   logic [2:0]          fmt;
   logic [63:0]         hdr1_data;
   logic [7:0]          hdr1_keep;
   logic                unused_bits;

   // rr_ready guard keeps a still-high rr_valid from being taken twice
   assign accept    = (state == IDLE) && rr_valid && !rr_ready;
   assign tag_count = tag_cnt;

`ifdef HIFIFO_RR_4DW_EN
   logic [31:0] addr_hi_q;
   logic        is_4dw;

   assign is_4dw      = (addr_hi_q != 32'h0);
   assign fmt         = is_4dw ? FMT_4DW_NODATA : FMT_3DW_NODATA;
   assign hdr1_data   = is_4dw ? {addr_lo_q, 2'b00, addr_hi_q} : {32'h0, addr_lo_q, 2'b00};
   assign hdr1_keep   = is_4dw ? 8'hFF : 8'h0F;
   assign unused_bits = ^rr_addr[1:0];

   // upper address half only exists when 4DW headers can be emitted
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    addr_hi_q <= 32'h0;
      else if (accept) addr_hi_q <= rr_addr[63:32];
   end
`else
   assign fmt         = FMT_3DW_NODATA;
   assign hdr1_data   = {32'h0, addr_lo_q, 2'b00};
   assign hdr1_keep   = 8'h0F;
   assign unused_bits = ^{rr_addr[63:32], rr_addr[1:0]};
`endif

   // state, accept pulse and tag counter; tag advances when the TLP's last beat leaves
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rr_ready <= 1'b0;
         tag_cnt  <= '0;
      end else begin
         state    <= state_next;
         rr_ready <= accept;
         if (state == HDR1 && tx_ready) tag_cnt <= tag_cnt + 1'b1;
      end
   end

   // capture the request at accept so later rr_addr/requester_id changes are ignored
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_lo_q <= '0;
         req_id_q  <= 16'h0;
         tag_q     <= 8'h0;
      end else if (accept) begin
         addr_lo_q <= rr_addr[31:2];
         req_id_q  <= requester_id;
         tag_q     <= {TAG_BASE, tag_cnt};
      end
   end

   // next state and beat outputs; outputs derive only from state and captured fields so they hold while stalled
   always_comb begin
      state_next = state;
      tx_valid   = 1'b0;
      tx_last    = 1'b0;
      tx_keep    = 8'h00;
      tx_data    = 64'h0;
      case (state)
         IDLE: begin
            if (accept) state_next = HDR0;
         end
         HDR0: begin
            tx_valid = 1'b1;
            tx_keep  = 8'hFF;
            tx_data  = {req_id_q, tag_q, 4'hF, 4'hF, build_dw0(fmt, LEN_FIELD)};
            if (tx_ready) state_next = HDR1;
         end
         HDR1: begin
            tx_valid = 1'b1;
            tx_last  = 1'b1;
            tx_keep  = hdr1_keep;
            tx_data  = hdr1_data;
            if (tx_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_hififo_rr_tlp.sv
// tb/tb_hififo_rr_tlp.sv - scoreboard bench for hififo_rr_tlp
module tb_hififo_rr_tlp;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] requester_id = 16'h0;
   logic        rr_valid = 1'b0;
   logic [63:0] rr_addr = 64'h0;
   logic        rr_ready;
   logic [63:0] tx_data;
   logic [7:0]  tx_keep;
   logic        tx_valid;
   logic        tx_last;
   logic        tx_ready = 1'b0;
   logic [2:0]  tag_count;

   beat_t       exp_q[$];
   logic [63:0] pend_q[$];
   int          pulse_cyc[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          pulses = 0;
   int          cyc = 0;
   int          mode = 0;
   logic [7:0]  tag_model = 8'h0;
   logic [15:0] pat = 16'b1011_0010_0111_0100;
   logic        prev_stall = 1'b0;
   beat_t       prev_beat;

   hififo_rr_tlp dut (
      .clock(clock), .reset_n(reset_n), .requester_id(requester_id),
      .rr_valid(rr_valid), .rr_addr(rr_addr), .rr_ready(rr_ready),
      .tx_data(tx_data), .tx_keep(tx_keep), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_ready(tx_ready), .tag_count(tag_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic beat_t model_beat0(input logic [15:0] rid, input logic [7:0] tag, input logic [63:0] a);
      logic [2:0] f;
      f = 3'b000;
`ifdef HIFIFO_RR_4DW_EN
      if (a[63:32] != 32'h0) f = 3'b001;
`endif
      return '{data: {rid, tag, 8'hFF, f, 5'b00000, 8'h00, 6'h00, 10'd128}, keep: 8'hFF, last: 1'b0};
   endfunction

   function automatic beat_t model_beat1(input logic [63:0] a);
`ifdef HIFIFO_RR_4DW_EN
      if (a[63:32] != 32'h0) return '{data: {a[31:0], a[63:32]}, keep: 8'hFF, last: 1'b1};
`endif
      return '{data: {32'h0, a[31:0]}, keep: 8'h0F, last: 1'b1};
   endfunction

   task automatic push_exp(input logic [63:0] d, input logic [7:0] k, input logic l);
      exp_q.push_back('{data: d, keep: k, last: l});
   endtask

   task automatic req(input logic [63:0] a);
      exp_q.push_back(model_beat0(requester_id, tag_model, a));
      exp_q.push_back(model_beat1(a));
      tag_model = {5'b0, tag_model[2:0] + 3'd1};
      pend_q.push_back(a);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || pend_q.size() != 0) && n < budget) begin
         @(posedge clock);
         n++;
      end
      chk("drain", 64'(exp_q.size() + pend_q.size()), 64'd0);
      repeat (2) @(posedge clock);
      #3;
   endtask

   // request FIFO model: pointer advances once per observed rr_ready pulse
   initial begin
      logic took;
      forever begin
         @(negedge clock);
         took = reset_n && rr_ready;
         @(posedge clock);
         #1;
         if (took && pend_q.size() > 0) void'(pend_q.pop_front());
         if (pend_q.size() > 0) begin
            rr_valid = 1'b1;
            rr_addr  = pend_q[0];
         end else begin
            rr_valid = 1'b0;
            rr_addr  = 64'hDEAD_BEEF_0000_0E00 ^ 64'(cyc);
         end
      end
   end

   // TX sink: 0 always ready, 1 pattern, 2 stall in last beat, 3 never ready
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (mode)
            0: tx_ready = 1'b1;
            1: begin
               tx_ready = pat[15];
               pat = {pat[14:0], pat[15]};
            end
            2: tx_ready = !(tx_valid && tx_last);
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // monitor: stability while stalled, scoreboard on every accepted beat
   always @(negedge clock) begin
      beat_t e;
      cyc++;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (rr_ready) begin
            pulses++;
            pulse_cyc.push_back(cyc);
         end
         if (prev_stall) begin
            chk("held_valid", 64'(tx_valid), 64'd1);
            chk("held_data", tx_data, prev_beat.data);
            chk("held_keep", 64'(tx_keep), 64'(prev_beat.keep));
            chk("held_last", 64'(tx_last), 64'(prev_beat.last));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat: got %h expected none", tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", tx_data, e.data);
               chk("beat_keep", 64'(tx_keep), 64'(e.keep));
               chk("beat_last", 64'(tx_last), 64'(e.last));
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_beat  = '{data: tx_data, keep: tx_keep, last: tx_last};
      end
   end

   initial begin
      int p0;
      int c0;
      int n;
      #2;
      chk("rst_rr_ready", 64'(rr_ready), 64'd0);
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_tx_last", 64'(tx_last), 64'd0);
      chk("rst_tx_keep", 64'(tx_keep), 64'd0);
      chk("rst_tx_data", tx_data, 64'd0);
      chk("rst_tag_count", 64'(tag_count), 64'd0);
      @(posedge clock);
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      mode = 0;
      requester_id = 16'h0100;

      // basic 3DW read
      @(posedge clock);
      #3;
      p0 = pulses;
      push_exp(64'h0100_00FF_0000_0080, 8'hFF, 1'b0);
      push_exp(64'h0000_0000_1234_5E00, 8'h0F, 1'b1);
      tag_model = 8'h1;
      pend_q.push_back(64'h0000_0000_1234_5E00);
      wait_drain(50);
      chk("t1_pulses", 64'(pulses - p0), 64'd1);

      // address above 4 GiB
`ifdef HIFIFO_RR_4DW_EN
      push_exp(64'h0100_01FF_2000_0080, 8'hFF, 1'b0);
      push_exp(64'h0000_0200_0000_0001, 8'hFF, 1'b1);
`else
      push_exp(64'h0100_01FF_0000_0080, 8'hFF, 1'b0);
      push_exp(64'h0000_0000_0000_0200, 8'h0F, 1'b1);
`endif
      tag_model = 8'h2;
      pend_q.push_back(64'h0000_0001_0000_0200);
      wait_drain(50);

      // pseudo-random backpressure
      mode = 1;
      requester_id = 16'hABCD;
      req(64'h0000_0000_8000_0000);
      req(64'h0000_0000_0000_0600);
      req(64'h0000_0000_FFFF_FE00);
      wait_drain(300);
      mode = 0;

      // reset while the last beat is stalled
      mode = 2;
      req(64'h0000_0000_0000_4000);
      n = 0;
      while (!(tx_valid && tx_last) && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("t4_in_hdr1", 64'(tx_valid && tx_last), 64'd1);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      pend_q.delete();
      tag_model = 8'h0;
      #1;
      chk("t4_tx_valid", 64'(tx_valid), 64'd0);
      chk("t4_rr_ready", 64'(rr_ready), 64'd0);
      chk("t4_tx_last", 64'(tx_last), 64'd0);
      chk("t4_tag_count", 64'(tag_count), 64'd0);
      @(posedge clock);
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      mode = 0;

      // nine back-to-back requests: tags 0..7,0 at one per 3 cycles
      requester_id = 16'h0203;
      p0 = pulses;
      c0 = pulse_cyc.size();
      for (int i = 0; i < 9; i++) req(64'h0000_0000_0010_0000 + 64'(i * 512));
      wait_drain(100);
      chk("t5_pulses", 64'(pulses - p0), 64'd9);
      if (pulse_cyc.size() >= c0 + 9) begin
         for (int i = 1; i < 9; i++)
            chk("t5_spacing", 64'(pulse_cyc[c0 + i] - pulse_cyc[c0 + i - 1]), 64'd3);
      end
      chk("t5_tag_count", 64'(tag_count), 64'd1);

      // rr_valid held high while the core never accepts
      mode = 3;
      p0 = pulses;
      req(64'h0000_0000_0ABC_0000);
      req(64'h0000_0000_0ABC_0200);
      repeat (12) @(posedge clock);
      #3;
      chk("t6_one_pulse", 64'(pulses - p0), 64'd1);
      chk("t6_tx_valid", 64'(tx_valid), 64'd1);
      chk("t6_tx_last", 64'(tx_last), 64'd0);
      mode = 0;
      wait_drain(100);
      chk("t6_pulses", 64'(pulses - p0), 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
